// File: rtl/cv32e40p_vseq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_vseq_pkg
// Description : Shared types and constants for the vector register / memory
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package cv32e40p_vseq_pkg;

    localparam int NUM_VREG = 11;
    localparam int LANES    = 4;
    localparam int LANE_W   = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } vseq_state_e;

    typedef struct packed {
        logic        store;
        logic [3:0]  vreg;
        logic [31:0] addr;
        logic [2:0]  lanes;
    } vseq_cmd_t;

endpackage
`default_nettype wire

// File: rtl/cv32e40p_vreg_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_vreg_mem_sequencer
// Description : Splits 128-bit vector loads/stores into 32-bit OBI word
//               transactions, one outstanding at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module cv32e40p_vreg_mem_sequencer #(
    parameter int NUM_VREG = cv32e40p_vseq_pkg::NUM_VREG,
    parameter int LANES    = cv32e40p_vseq_pkg::LANES
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      cmd_valid_i,
    output logic                                      cmd_ready_o,
    input  logic                                      cmd_store_i,
    input  logic [3:0]                                cmd_vreg_i,
    input  logic [31:0]                               cmd_addr_i,
    input  logic [2:0]                                cmd_lanes_i,
    output logic                                      busy_o,
    output logic                                      done_o,
    output logic                                      err_o,
    output logic                                      vrf_we_o,
    output logic [3:0]                                vrf_waddr_o,
    output logic [LANES*cv32e40p_vseq_pkg::LANE_W-1:0] vrf_wdata_o,
    output logic [LANES-1:0]                          vrf_wmask_o,
    output logic [3:0]                                vrf_raddr_o,
    input  logic [LANES*cv32e40p_vseq_pkg::LANE_W-1:0] vrf_rdata_i,
    output logic                                      data_req_o,
    input  logic                                      data_gnt_i,
    output logic [31:0]                               data_addr_o,
    output logic                                      data_we_o,
    output logic [3:0]                                data_be_o,
    output logic [31:0]                               data_wdata_o,
    input  logic                                      data_rvalid_i,
    input  logic [31:0]                               data_rdata_i
);
    import cv32e40p_vseq_pkg::*;

    vseq_state_e                r_state;
    vseq_cmd_t                  r_cmd;
    logic                       r_err;
    logic [LANES*LANE_W-1:0]    r_buf;
    logic [1:0]                 r_cnt;

    logic                       w_illegal;
    logic                       w_last;
    logic                       w_req;
    logic                       w_vrf_wr;
    logic [LANES-1:0]           w_mask;
    logic [LANES*LANE_W-1:0]    w_buf_masked;
    logic [LANE_W-1:0]          w_lane_word;

    assign w_illegal = (int'(cmd_vreg_i) >= NUM_VREG) || (cmd_lanes_i == 3'd0) ||
                       (int'(cmd_lanes_i) > LANES) || (cmd_addr_i[1:0] != 2'b00);
    assign w_last      = ({1'b0, r_cnt} == (r_cmd.lanes - 3'd1));
    assign w_lane_word = r_buf[{r_cnt, 5'b00000} +: LANE_W];

    always_comb begin
        w_mask       = '0;
        w_buf_masked = '0;
        for (int i = 0; i < LANES; i++) begin
            w_mask[i] = (i < int'(r_cmd.lanes));
            w_buf_masked[i*LANE_W +: LANE_W] = w_mask[i] ? r_buf[i*LANE_W +: LANE_W] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cmd   <= '0;
            r_err   <= 1'b0;
            r_buf   <= '0;
            r_cnt   <= 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        if (w_illegal) begin
                            r_err   <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_err   <= 1'b0;
                            r_cmd   <= '{store: cmd_store_i, vreg: cmd_vreg_i,
                                         addr: cmd_addr_i, lanes: cmd_lanes_i};
                            r_cnt   <= 2'd0;
                            // Loads start from a clean buffer so unloaded lanes read as zero.
                            r_buf   <= cmd_store_i ? vrf_rdata_i : '0;
                            r_state <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (data_gnt_i) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (data_rvalid_i) begin
                        if (!r_cmd.store) begin
                            r_buf[{r_cnt, 5'b00000} +: LANE_W] <= data_rdata_i;
                        end
                        if (w_last) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_cnt   <= r_cnt + 2'd1;
                            r_state <= ST_REQ;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_req    = (r_state == ST_REQ);
    assign w_vrf_wr = (r_state == ST_DONE) && !r_err && !r_cmd.store;

    assign cmd_ready_o  = (r_state == ST_IDLE);
    assign busy_o       = (r_state != ST_IDLE);
    assign done_o       = (r_state == ST_DONE);
    assign err_o        = (r_state == ST_DONE) && r_err;

    assign vrf_raddr_o  = cmd_vreg_i;
    assign vrf_we_o     = w_vrf_wr;
    assign vrf_waddr_o  = w_vrf_wr ? r_cmd.vreg   : 4'd0;
    assign vrf_wdata_o  = w_vrf_wr ? w_buf_masked : '0;
    assign vrf_wmask_o  = w_vrf_wr ? w_mask       : '0;

    // Address arithmetic is plain 32-bit, so it wraps past 0xFFFFFFFC.
    assign data_req_o   = w_req;
    assign data_addr_o  = w_req ? (r_cmd.addr + {28'd0, r_cnt, 2'b00}) : 32'd0;
    assign data_we_o    = w_req && r_cmd.store;
    assign data_wdata_o = (w_req && r_cmd.store) ? w_lane_word : 32'd0;
    assign data_be_o    = 4'hF;

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_vreg_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cv32e40p_vreg_mem_sequencer
// Description : Directed plus randomized bench with an abstract model of the
//               memory sequencer's expected transactions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cv32e40p_vreg_mem_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid, cmd_ready, cmd_store;
    logic [3:0]   cmd_vreg;
    logic [31:0]  cmd_addr;
    logic [2:0]   cmd_lanes;
    logic         busy, done, err;
    logic         vrf_we;
    logic [3:0]   vrf_waddr, vrf_raddr;
    logic [127:0] vrf_wdata, vrf_rdata;
    logic [3:0]   vrf_wmask;
    logic         data_req, data_gnt, data_we, data_rvalid;
    logic [31:0]  data_addr, data_wdata, data_rdata;
    logic [3:0]   data_be;

    logic [127:0] vrf_model [16];
    logic [31:0]  rd_words  [4];
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    assign vrf_rdata = vrf_model[vrf_raddr];

    cv32e40p_vreg_mem_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_store_i   (cmd_store),
        .cmd_vreg_i    (cmd_vreg),
        .cmd_addr_i    (cmd_addr),
        .cmd_lanes_i   (cmd_lanes),
        .busy_o        (busy),
        .done_o        (done),
        .err_o         (err),
        .vrf_we_o      (vrf_we),
        .vrf_waddr_o   (vrf_waddr),
        .vrf_wdata_o   (vrf_wdata),
        .vrf_wmask_o   (vrf_wmask),
        .vrf_raddr_o   (vrf_raddr),
        .vrf_rdata_i   (vrf_rdata),
        .data_req_o    (data_req),
        .data_gnt_i    (data_gnt),
        .data_addr_o   (data_addr),
        .data_we_o     (data_we),
        .data_be_o     (data_be),
        .data_wdata_o  (data_wdata),
        .data_rvalid_i (data_rvalid),
        .data_rdata_i  (data_rdata)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one command through its whole life and checks every cycle against
    // what the command rules say must happen.
    task automatic run_cmd(input logic st, input logic [3:0] vr, input logic [31:0] ad,
                           input logic [2:0] ln, input int gd, input int rd);
        logic         illegal;
        logic [127:0] exp_v;
        logic [31:0]  ea;
        int           m;
        illegal = (vr >= 4'd11) || (ln == 3'd0) || (ln > 3'd4) || (ad[1:0] != 2'b00);
        cmd_valid = 1'b1;
        cmd_store = st;
        cmd_vreg  = vr;
        cmd_addr  = ad;
        cmd_lanes = ln;
        chk("accept_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        cmd_vreg  = 4'($urandom);
        cmd_addr  = $urandom;
        cmd_lanes = 3'($urandom);
        if (illegal) begin
            chk("err_done", done, 1);
            chk("err_err", err, 1);
            chk("err_req", data_req, 0);
            chk("err_vrf_we", vrf_we, 0);
            chk("err_ready", cmd_ready, 0);
            step();
            chk("err_after_done", done, 0);
            chk("err_after_ready", cmd_ready, 1);
            return;
        end
        exp_v = '0;
        for (int l = 0; l < int'(ln); l++) begin
            ea = ad + 32'(4 * l);
            for (int d = 0; d <= gd; d++) begin
                chk("req", data_req, 1);
                chk("addr", data_addr, ea);
                chk("we", data_we, st);
                chk("be", data_be, 4'hF);
                if (st) chk("wdata", data_wdata, vrf_model[vr][32*l +: 32]);
                chk("ready_busy", {cmd_ready, busy}, 2'b01);
                chk("req_vrf_we", vrf_we, 0);
                data_gnt    = (d == gd);
                data_rvalid = (d < gd) && ($urandom_range(0, 1) == 1);
                data_rdata  = $urandom;
                step();
            end
            data_gnt    = 1'b0;
            data_rvalid = 1'b0;
            for (int d = 0; d <= rd; d++) begin
                chk("wait_req", data_req, 0);
                chk("wait_done", done, 0);
                data_rvalid = (d == rd);
                data_rdata  = rd_words[l];
                step();
            end
            data_rvalid = 1'b0;
            exp_v[32*l +: 32] = rd_words[l];
        end
        m = (1 << ln) - 1;
        chk("done", done, 1);
        chk("done_err", err, 0);
        chk("vrf_we", vrf_we, !st);
        if (!st) begin
            chk("vrf_waddr", vrf_waddr, vr);
            chk("vrf_wdata", vrf_wdata, exp_v);
            chk("vrf_wmask", vrf_wmask, 128'(m));
            vrf_model[vr] = exp_v;
        end
        step();
        chk("post_done", done, 0);
        chk("post_ready", cmd_ready, 1);
        chk("post_busy", busy, 0);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_store = 1'b0; cmd_vreg = '0;
        cmd_addr = '0; cmd_lanes = '0; data_gnt = 1'b0; data_rvalid = 1'b0;
        data_rdata = '0;
        for (int i = 0; i < 16; i++) vrf_model[i] = {$urandom, $urandom, $urandom, $urandom};
        step();
        step();
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done_err", {done, err}, 0);
        chk("rst_vrf", {vrf_we, vrf_wmask, vrf_waddr}, 0);
        chk("rst_vrf_wdata", vrf_wdata, 0);
        chk("rst_data", {data_req, data_we}, 0);
        chk("rst_data_addr", data_addr, 0);
        chk("rst_data_wdata", data_wdata, 0);
        chk("rst_be", data_be, 4'hF);
        rst = 1'b0;
        step();

        // Full four-lane load, zero-wait memory.
        rd_words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        run_cmd(1'b0, 4'd3, 32'h1000, 3'd4, 0, 0);

        // Two-lane store with a stalled grant.
        vrf_model[5] = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        run_cmd(1'b1, 4'd5, 32'h2000, 3'd2, 3, 0);

        // Illegal commands.
        run_cmd(1'b0, 4'd11, 32'h1000, 3'd4, 0, 0);
        run_cmd(1'b0, 4'd1,  32'h1000, 3'd0, 0, 0);
        run_cmd(1'b0, 4'd1,  32'h1000, 3'd5, 0, 0);
        run_cmd(1'b1, 4'd1,  32'h1002, 3'd4, 0, 0);

        // Address wrap and partial load.
        rd_words = '{$urandom, $urandom, $urandom, $urandom};
        run_cmd(1'b0, 4'd7, 32'hFFFFFFF8, 3'd4, 1, 1);
        rd_words = '{32'hA, 32'hB, $urandom, $urandom};
        run_cmd(1'b0, 4'd2, 32'h4000, 3'd2, 0, 0);

        // Reset while waiting on the second lane's response.
        cmd_valid = 1'b1; cmd_store = 1'b0; cmd_vreg = 4'd4;
        cmd_addr = 32'h3000; cmd_lanes = 3'd4;
        step();
        cmd_valid = 1'b0;
        data_gnt = 1'b1; step();
        data_gnt = 1'b0; data_rvalid = 1'b1; data_rdata = 32'hCAFE0000; step();
        data_rvalid = 1'b0; data_gnt = 1'b1; step();
        data_gnt = 1'b0;
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1; step();
        rst = 1'b0;
        chk("rst_mid_req", data_req, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_ready", cmd_ready, 1);
        chk("rst_mid_done", done, 0);
        data_rvalid = 1'b1; data_rdata = 32'hDEAD0001; step();
        data_rvalid = 1'b0;
        chk("stray_vrf_we", vrf_we, 0);
        chk("stray_done", done, 0);
        step();
        chk("stray_vrf_we2", vrf_we, 0);
        rd_words = '{$urandom, $urandom, $urandom, $urandom};
        run_cmd(1'b0, 4'd4, 32'h3000, 3'd4, 0, 0);

        // Randomized commands, occasionally illegal.
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
            rd_words = '{$urandom, $urandom, $urandom, $urandom};
            run_cmd(1'($urandom), 4'($urandom_range(0, 12)), a,
                    3'($urandom_range(0, 5)), $urandom_range(0, 3), $urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
